// File: rtl/alu_result_queue.sv
// alu_result_queue: registered FIFO stage behind the ALU with valid/ready handshake and sticky exception flags
//   clk, rst_n (sync, active-low)
//   in_valid/in_ready, in_sel[5], in_result[16], in_upper[16], in_flags[9]   producer side
//   out_valid/out_ready, out_sel, out_result, out_upper, out_flags          head entry, consumer side
//   level[CW]    entries stored
//   sticky[4]    {divbyzero,overflow,borrow,carry} accumulated over pushes
//   sticky_clr   clear sticky; a push in the same cycle replaces it with its own flags
module alu_result_queue #(
    parameter int DEPTH = 2,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [4:0]    in_sel,
    input  logic [15:0]   in_result,
    input  logic [15:0]   in_upper,
    input  logic [8:0]    in_flags,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [4:0]    out_sel,
    output logic [15:0]   out_result,
    output logic [15:0]   out_upper,
    output logic [8:0]    out_flags,
    output logic [CW-1:0] level,
    output logic [3:0]    sticky,
    input  logic          sticky_clr
);
    localparam int AW = $clog2(DEPTH);
    logic [45:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          push, pop;
    assign in_ready  = level != CW'(DEPTH);
    assign out_valid = level != '0;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign {out_sel, out_result, out_upper, out_flags} = mem[rd_ptr];
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            level  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            sticky <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= {in_sel, in_result, in_upper, in_flags};
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push != pop) level <= push ? level + 1'b1 : level - 1'b1;
            // in_flags[5:2] is {divbyzero,overflow,borrow,carry}
            if (push | sticky_clr)
                sticky <= (sticky_clr ? 4'b0 : sticky) | (push ? in_flags[5:2] : 4'b0);
        end
    end
endmodule
